// File: rtl/store_write_buffer_if.sv
// Store-input and memory-write handshake bundle for the store write buffer.
interface store_write_buffer_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  logic              in_valid;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic [BE_W-1:0]   in_be;
  logic              in_ready;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_gnt;

  // Buffer side: accepts stores, issues memory writes.
  modport slave (
    input  in_valid, in_addr, in_data, in_be, mem_gnt,
    output in_ready, mem_req, mem_addr, mem_wdata, mem_be
  );

  // Environment side: store queue plus data memory port.
  modport master (
    output in_valid, in_addr, in_data, in_be, mem_gnt,
    input  in_ready, mem_req, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/store_write_buffer.sv
// Post-commit store write buffer: circular FIFO draining to memory, with
// youngest-first load forwarding lookup and a fence drain mode.
module store_write_buffer #(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned IDX_W = $clog2(SIZE)
) (
  input  logic                clk,
  input  logic                rst,
  store_write_buffer_if.slave bus,
  input  logic [31:0]         lk_addr,
  output logic                lk_hit,
  output logic                lk_partial,
  output logic [31:0]         lk_data,
  input  logic                fence_req,
  output logic                fence_ack,
  output logic                empty,
  output logic [IDX_W:0]      count
);

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned WA_W  = 30;

  typedef enum logic [1:0] {IDLE, REQ, FENCE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WA_W-1:0]  addr_q [SIZE];
  logic [WA_W-1:0]  addr_d [SIZE];
  logic [31:0]      data_q [SIZE];
  logic [31:0]      data_d [SIZE];
  logic [3:0]       be_q   [SIZE];
  logic [3:0]       be_d   [SIZE];
  logic [SIZE-1:0]  vld_q, vld_d;

  logic in_ready_c;
  logic mem_req_c;
  logic push;
  logic pop;
  logic unused_addr_bits;

  // Handshake outputs are decoded from registered state only.
  assign in_ready_c    = (count_q < CNT_W'(SIZE)) && (state_q != FENCE);
  assign mem_req_c     = (state_q != IDLE) && (count_q != '0);
  assign push          = bus.in_valid && in_ready_c;
  assign pop           = mem_req_c && bus.mem_gnt;

  assign bus.in_ready  = in_ready_c;
  assign bus.mem_req   = mem_req_c;
  assign bus.mem_addr  = {addr_q[head_q], 2'b00};
  assign bus.mem_wdata = data_q[head_q];
  assign bus.mem_be    = be_q[head_q];

  assign fence_ack     = (state_q == FENCE) && (count_q == '0) && fence_req;
  assign empty         = (count_q == '0);
  assign count         = count_q;

  // Byte offsets are irrelevant: both store and lookup compare whole words.
  assign unused_addr_bits = ^{lk_addr[1:0], bus.in_addr[1:0]};

  // Forwarding lookup: walk oldest to youngest so the youngest match wins.
  always_comb begin
    logic [IDX_W-1:0] idx;
    lk_hit     = 1'b0;
    lk_partial = 1'b0;
    lk_data    = '0;
    idx        = '0;
    for (int unsigned k = 0; k < SIZE; k++) begin
      idx = head_q + IDX_W'(k);
      if (vld_q[idx] && (addr_q[idx] == lk_addr[31:2])) begin
        lk_hit     = (be_q[idx] == 4'hF);
        lk_partial = (be_q[idx] != 4'hF);
        lk_data    = (be_q[idx] == 4'hF) ? data_q[idx] : '0;
      end
    end
  end

  // Next-state: FIFO push/pop bookkeeping and the drain FSM.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    vld_d   = vld_q;

    // Push and pop never touch the same slot: pop needs count>0, push needs count<SIZE.
    if (push) begin
      addr_d[tail_q] = bus.in_addr[31:2];
      data_d[tail_q] = bus.in_data;
      be_d[tail_q]   = bus.in_be;
      vld_d[tail_q]  = 1'b1;
      tail_d         = tail_q + IDX_W'(1);
    end
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + IDX_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A pending fence pre-empts normal draining; FENCE drains identically.
    case (state_q)
      IDLE: begin
        if (fence_req)             state_d = FENCE;
        else if (count_q != '0)    state_d = REQ;
      end
      REQ: begin
        if (fence_req)             state_d = FENCE;
        else if (pop && (count_d == '0)) state_d = IDLE;
      end
      FENCE: begin
        if (!fence_req)            state_d = IDLE;
      end
      default:                     state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; reset abandons any outstanding write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      for (int unsigned i = 0; i < SIZE; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_store_write_buffer;
  localparam int unsigned SIZE = 4;
  localparam int unsigned CW   = 3;

  typedef struct {
    logic [29:0] wa;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   lk_addr;
  logic          lk_hit, lk_partial;
  logic [31:0]   lk_data;
  logic          fence_req, fence_ack, empty;
  logic [CW-1:0] count;

  int total = 0;
  int bad   = 0;

  store_write_buffer_if bus();

  store_write_buffer #(.SIZE(SIZE)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .lk_addr    (lk_addr),
    .lk_hit     (lk_hit),
    .lk_partial (lk_partial),
    .lk_data    (lk_data),
    .fence_req  (fence_req),
    .fence_ack  (fence_ack),
    .empty      (empty),
    .count      (count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_data  = '0;
    bus.in_be    = '0;
    bus.mem_gnt  = 1'b0;
    fence_req    = 1'b0;
    lk_addr      = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.in_valid = 1'b1;
    bus.in_addr  = a;
    bus.in_data  = d;
    bus.in_be    = be;
    tick();
    bus.in_valid = 1'b0;
  endtask

  function automatic void model_lookup(input ent_t q[$], input logic [31:0] la,
                                       output logic h, output logic p, output logic [31:0] d);
    h = 1'b0; p = 1'b0; d = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].wa == la[31:2]) begin
        if (q[i].be == 4'hF) begin h = 1'b1; d = q[i].data; end
        else p = 1'b1;
        break;
      end
    end
  endfunction

  task automatic test_reset();
    do_reset();
    lk_addr = 32'h0000_0100;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b exp=0", bus.mem_req); end
    total++; if ({lk_hit, lk_partial} !== 2'b00) begin bad++; $display("FAIL rst_lookup got=%b%b exp=00", lk_hit, lk_partial); end
    total++; if (lk_data !== 32'h0) begin bad++; $display("FAIL rst_lk_data got=%h exp=0", lk_data); end
    total++; if (fence_ack !== 1'b0) begin bad++; $display("FAIL rst_fence_ack got=%b exp=0", fence_ack); end
    total++; if (empty !== 1'b1 || count !== 3'd0) begin bad++; $display("FAIL rst_empty got=%b/%0d exp=1/0", empty, count); end
    tick();
  endtask

  task automatic test_fill();
    logic [31:0] a [5];
    logic [31:0] d [5];
    logic [3:0]  b [5];
    do_reset();
    for (int i = 0; i < 5; i++) begin
      a[i] = 32'h2000 + 32'(i * 4);
      d[i] = $urandom;
      b[i] = 4'($urandom_range(1, 15));
    end
    for (int i = 0; i < 4; i++) push(a[i], d[i], b[i]);
    bus.in_valid = 1'b1; bus.in_addr = a[4]; bus.in_data = d[4]; bus.in_be = b[4];
    @(negedge clk);
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", count); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b exp=0", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_5th_ignored got=%0d exp=4", count); end
    tick();
    bus.mem_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== a[i] || bus.mem_wdata !== d[i] || bus.mem_be !== b[i]) begin
        bad++;
        $display("FAIL fill_drain[%0d] got=%b %h %h %h exp=1 %h %h %h", i, bus.mem_req,
                 bus.mem_addr, bus.mem_wdata, bus.mem_be, a[i], d[i], b[i]);
      end
      tick();
    end
    bus.mem_gnt = 1'b0;
    @(negedge clk);
    total++; if (empty !== 1'b1 || bus.mem_req !== 1'b0) begin bad++; $display("FAIL fill_empty got=%b/%b exp=1/0", empty, bus.mem_req); end
    tick();
  endtask

  task automatic test_wrap();
    logic [29:0] q [$];
    int pushed = 0;
    int popped = 0;
    int cyc    = 0;
    int ec     = 0;
    logic rdy;
    do_reset();
    while (popped < 10 && cyc < 200) begin
      bus.in_valid = (pushed < 10);
      bus.in_addr  = 32'h4000 + 32'(pushed * 12);
      bus.in_data  = $urandom;
      bus.in_be    = 4'hF;
      bus.mem_gnt  = ((cyc % 2) == 1);
      @(negedge clk);
      rdy = (ec < 4);
      total++; if (count > 3'd4 || count !== 3'(ec)) begin bad++; $display("FAIL wrap_count cyc=%0d got=%0d exp=%0d", cyc, count, ec); end
      total++; if (bus.in_ready !== rdy) begin bad++; $display("FAIL wrap_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready, rdy); end
      if (bus.mem_req && bus.mem_gnt) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL wrap_order cyc=%0d got=%h exp=none", cyc, bus.mem_addr);
        end else begin
          if (bus.mem_addr !== {q[0], 2'b00}) begin
            bad++; $display("FAIL wrap_order cyc=%0d got=%h exp=%h", cyc, bus.mem_addr, {q[0], 2'b00});
          end
          void'(q.pop_front());
          ec--;
        end
        popped++;
      end
      if (bus.in_valid && rdy) begin
        q.push_back(bus.in_addr[31:2]);
        pushed++;
        ec++;
      end
      tick();
      cyc++;
    end
    idle_inputs();
    total++; if (popped < 10) begin bad++; $display("FAIL wrap_timeout got=%0d exp=10", popped); end
  endtask

  task automatic test_forward();
    do_reset();
    push(32'h100, 32'h11, 4'hF);
    push(32'h100, 32'h22, 4'hF);
    lk_addr = 32'h102;
    @(negedge clk);
    total++; if (lk_hit !== 1'b1 || lk_partial !== 1'b0 || lk_data !== 32'h22) begin
      bad++; $display("FAIL fwd_youngest got=%b%b %h exp=10 00000022", lk_hit, lk_partial, lk_data); end
    tick();
    lk_addr = 32'h200;
    @(negedge clk);
    total++; if (lk_hit !== 1'b0 || lk_partial !== 1'b0 || lk_data !== 32'h0) begin
      bad++; $display("FAIL fwd_nomatch got=%b%b %h exp=00 0", lk_hit, lk_partial, lk_data); end
    tick();
    push(32'h100, 32'h33, 4'h3);
    lk_addr = 32'h101;
    @(negedge clk);
    total++; if (lk_hit !== 1'b0 || lk_partial !== 1'b1) begin
      bad++; $display("FAIL fwd_partial got=%b%b exp=01", lk_hit, lk_partial); end
    tick();
    bus.in_valid = 1'b1; bus.in_addr = 32'h104; bus.in_data = 32'h44; bus.in_be = 4'hF;
    lk_addr = 32'h104;
    @(negedge clk);
    total++; if (lk_hit !== 1'b0 || lk_partial !== 1'b0) begin
      bad++; $display("FAIL fwd_push_hidden got=%b%b exp=00", lk_hit, lk_partial); end
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    total++; if (lk_hit !== 1'b1 || lk_data !== 32'h44) begin
      bad++; $display("FAIL fwd_push_visible got=%b %h exp=1 00000044", lk_hit, lk_data); end
    tick();
  endtask

  task automatic test_fence();
    logic [31:0] a [3];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a[i] = 32'h800 + 32'(i * 4);
      push(a[i], $urandom, 4'hF);
    end
    fence_req = 1'b1;
    tick();
    bus.in_valid = 1'b1; bus.in_addr = 32'h900; bus.in_be = 4'hF;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b0 || count !== 3'd3 || fence_ack !== 1'b0) begin
      bad++; $display("FAIL fence_enter got=%b/%0d/%b exp=0/3/0", bus.in_ready, count, fence_ack); end
    tick();
    bus.mem_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== a[i] || fence_ack !== 1'b0) begin
        bad++; $display("FAIL fence_drain[%0d] got=%b %h ack=%b exp=1 %h ack=0", i, bus.mem_req, bus.mem_addr, fence_ack, a[i]); end
      tick();
    end
    bus.mem_gnt = 1'b0;
    @(negedge clk);
    total++; if (fence_ack !== 1'b1 || count !== 3'd0 || bus.mem_req !== 1'b0) begin
      bad++; $display("FAIL fence_ack got=%b/%0d/%b exp=1/0/0", fence_ack, count, bus.mem_req); end
    tick();
    @(negedge clk);
    total++; if (fence_ack !== 1'b1) begin bad++; $display("FAIL fence_ack_hold got=%b exp=1", fence_ack); end
    tick();
    fence_req = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    total++; if (fence_ack !== 1'b0) begin bad++; $display("FAIL fence_ack_drop got=%b exp=0", fence_ack); end
    tick();
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1 || empty !== 1'b1) begin
      bad++; $display("FAIL fence_exit got=%b/%b exp=1/1", bus.in_ready, empty); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] da, dc;
    da = $urandom; dc = $urandom;
    do_reset();
    push(32'h300, da, 4'hF);
    push(32'h304, $urandom, 4'hF);
    bus.in_valid = 1'b1; bus.in_addr = 32'h308; bus.in_data = dc; bus.in_be = 4'hF;
    bus.mem_gnt = 1'b1;
    lk_addr = 32'h300;
    @(negedge clk);
    total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h300 || lk_hit !== 1'b1 || lk_data !== da) begin
      bad++; $display("FAIL b2b_pop_visible got=%b %h %b %h exp=1 300 1 %h", bus.mem_req, bus.mem_addr, lk_hit, lk_data, da); end
    tick();
    bus.in_valid = 1'b0; bus.mem_gnt = 1'b0;
    lk_addr = 32'h308;
    @(negedge clk);
    total++; if (count !== 3'd2 || lk_hit !== 1'b1 || lk_data !== dc) begin
      bad++; $display("FAIL b2b_count got=%0d %b %h exp=2 1 %h", count, lk_hit, lk_data, dc); end
    tick();
    lk_addr = 32'h300;
    @(negedge clk);
    total++; if (lk_hit !== 1'b0 || lk_partial !== 1'b0) begin
      bad++; $display("FAIL b2b_popped_gone got=%b%b exp=00", lk_hit, lk_partial); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) push(32'hA00 + 32'(i * 4), $urandom, 4'hF);
    @(negedge clk);
    total++; if (bus.mem_req !== 1'b1 || count !== 3'd3) begin
      bad++; $display("FAIL rstmid_pre got=%b/%0d exp=1/3", bus.mem_req, count); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.mem_req !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin
      bad++; $display("FAIL rstmid_post got=%b/%0d/%b exp=0/0/1", bus.mem_req, count, empty); end
    tick();
  endtask

  task automatic test_random();
    ent_t q [$];
    ent_t e;
    logic fm, rdy, eh, ep;
    logic [31:0] ed;
    int stall = 0;
    do_reset();
    fm = 1'b0;
    for (int c = 0; c < 600; c++) begin
      bus.in_valid = ($urandom_range(0, 2) != 0);
      bus.in_addr  = 32'h1000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      bus.in_data  = $urandom;
      bus.in_be    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
      bus.mem_gnt  = ($urandom_range(0, 1) == 1);
      if (fence_req) begin if ($urandom_range(0, 3) == 0) fence_req = 1'b0; end
      else if ($urandom_range(0, 23) == 0) fence_req = 1'b1;
      lk_addr = 32'h1000 + 32'($urandom_range(0, 9) * 4) + 32'($urandom_range(0, 3));
      @(negedge clk);
      rdy = (q.size() < SIZE) && !fm;
      total++; if (bus.in_ready !== rdy) begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, bus.in_ready, rdy); end
      total++; if (count !== 3'(q.size()) || empty !== (q.size() == 0)) begin
        bad++; $display("FAIL rnd_count c=%0d got=%0d/%b exp=%0d", c, count, empty, q.size()); end
      total++; if (fence_ack !== (fm && q.size() == 0 && fence_req)) begin
        bad++; $display("FAIL rnd_fence_ack c=%0d got=%b", c, fence_ack); end
      model_lookup(q, lk_addr, eh, ep, ed);
      total++; if (lk_hit !== eh || lk_partial !== ep || (eh && lk_data !== ed) || (!eh && !ep && lk_data !== 32'h0)) begin
        bad++; $display("FAIL rnd_lookup c=%0d addr=%h got=%b%b %h exp=%b%b %h", c, lk_addr, lk_hit, lk_partial, lk_data, eh, ep, ed); end
      if (bus.mem_req) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rnd_mem_req c=%0d got=1 exp=0", c);
        end else if (bus.mem_addr !== {q[0].wa, 2'b00} || bus.mem_wdata !== q[0].data || bus.mem_be !== q[0].be) begin
          bad++; $display("FAIL rnd_mem_head c=%0d got=%h %h %h exp=%h %h %h", c, bus.mem_addr, bus.mem_wdata,
                          bus.mem_be, {q[0].wa, 2'b00}, q[0].data, q[0].be);
        end
      end
      if (q.size() != 0 && !bus.mem_req) stall++; else stall = 0;
      total++; if (stall > 1) begin bad++; $display("FAIL rnd_stall c=%0d got=%0d exp<=1", c, stall); end
      if (bus.mem_req && bus.mem_gnt && q.size() != 0) void'(q.pop_front());
      if (bus.in_valid && rdy) begin
        e.wa = bus.in_addr[31:2]; e.data = bus.in_data; e.be = bus.in_be;
        q.push_back(e);
      end
      fm = fence_req;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_fill();
    test_wrap();
    test_forward();
    test_fence();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
